// File: rtl/proc_pkg.sv
// Shared pipeline constants and the skid-buffer occupancy encoding.
// The occupancy code is {M valid, S valid}.
package proc_pkg;

  localparam int WORD_W     = 32;
  localparam int DEF_NUM_IN = 4;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b10,
    SKID_FULL  = 2'b11
  } skid_state_e;

endpackage

// File: rtl/mux_n_to_1_comb.sv
// Combinational N:1 word select.
// Selects at or above NUM_IN give a zero word and raise err.
module mux_n_to_1_comb #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4
) (
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  input  logic [$clog2(NUM_IN)-1:0] sel,
  output logic [WIDTH-1:0]          word,
  output logic                      err
);

  localparam int SEL_W = $clog2(NUM_IN);

  always_comb begin
    word = '0;
    err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        word = in_data[k*WIDTH +: WIDTH];
        err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_n_to_1_pipe.sv
// Registered N:1 select stage with a 2-entry skid buffer (M drives outputs, S holds overflow).
// in_ready depends only on local flops and flush, never on out_ready.
//
//   state | meaning
//   EMPTY | nothing held, outputs idle
//   ONE   | word in M, S free
//   FULL  | words in M and S, upstream stalled
module mux_n_to_1_pipe
  import proc_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int NUM_IN = DEF_NUM_IN
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  input  logic [$clog2(NUM_IN)-1:0] sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      flush,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_selerr,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int SEL_W = $clog2(NUM_IN);

  logic [SEL_W-1:0] w_sel;
  logic [WIDTH-1:0] w_word;
  logic             w_err;
  logic             w_in_fire;
  logic             w_out_fire;
  skid_state_e      w_state;

  logic             r_rst_ok;
  logic             r_m_valid;
  logic [WIDTH-1:0] r_m_data;
  logic             r_m_err;
  logic             r_s_valid;
  logic [WIDTH-1:0] r_s_data;
  logic             r_s_err;

  assign w_sel = sel;

  mux_n_to_1_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_sel (
    .in_data (in_data),
    .sel     (w_sel),
    .word    (w_word),
    .err     (w_err)
  );

  // r_rst_ok keeps in_ready low until the first edge after reset release
  assign in_ready   = r_rst_ok & ~r_s_valid & ~flush;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_m_valid & out_ready;
  assign w_state    = skid_state_e'({r_m_valid, r_s_valid});

  assign out_valid  = r_m_valid;
  assign out_data   = r_m_valid ? r_m_data : '0;
  assign out_selerr = r_m_valid & r_m_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_ok  <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_err   <= 1'b0;
      r_s_valid <= 1'b0;
      r_s_data  <= '0;
      r_s_err   <= 1'b0;
    end else begin
      r_rst_ok <= 1'b1;
      if (flush) begin
        r_m_valid <= 1'b0;
        r_s_valid <= 1'b0;
      end else begin
        case (w_state)
          SKID_EMPTY: begin
            if (w_in_fire) begin
              r_m_valid <= 1'b1;
              r_m_data  <= w_word;
              r_m_err   <= w_err;
            end
          end
          SKID_ONE: begin
            if (w_in_fire && w_out_fire) begin
              r_m_data <= w_word;
              r_m_err  <= w_err;
            end else if (w_in_fire) begin
              r_s_valid <= 1'b1;
              r_s_data  <= w_word;
              r_s_err   <= w_err;
            end else if (w_out_fire) begin
              r_m_valid <= 1'b0;
            end
          end
          SKID_FULL: begin
            if (w_out_fire) begin
              r_m_data  <= r_s_data;
              r_m_err   <= r_s_err;
              r_s_valid <= 1'b0;
            end
          end
          default: begin
            // S without M cannot arise; recover to empty
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
